output_port_arbiter: RTL and testbench
======================================

Name: output_port_arbiter

Overview:
- Per-output-port allocator for the 4x4 mesh router. Sits directly downstream of the NUM_IN buffer_unit instances that compete for one router output.
- Consumes each buffer_unit's req_port and returns grant_port, using round-robin, packet-granular arbitration.
- While a grant is held, it muxes the owner's flit stream and four-phase req/ack handshake onto the output link (neighbour router or local node).

Parameters:
- NUM_IN, 5, number of competing buffer units (N/E/S/W/local).
- DATA_WIDTH, 18, flit width.
- CNT_WIDTH, 16, width of the granted-packet counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req_port  input  NUM_IN  per-input packet request from buffer_unit.req_port; held high for the whole packet.
- grant_port  output  NUM_IN  one-hot (or zero) grant to buffer_unit.grant_port.
- data_in  input  NUM_IN*DATA_WIDTH  flattened buffer_unit.data_out; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- req_in  input  NUM_IN  buffer_unit.req_out per input.
- ack_out  output  NUM_IN  to buffer_unit.ack_in per input.
- data_out  output  DATA_WIDTH  flit to downstream link.
- req_out  output  1  handshake request to downstream.
- ack_in  input  1  handshake acknowledge from downstream.
- busy  output  1  high while a grant is held.
- pkt_count  output  CNT_WIDTH  number of grants issued since reset.

Behaviour:
- Reset (rst=0, takes effect immediately, asynchronous):
  - grant_port=0, busy=0, pkt_count=0, rr pointer ptr=0, state=IDLE.
  - Because the datapath outputs are gated by the grant, req_out=0, data_out=0 and ack_out=0 while in reset.
- State machine is IDLE -> GRANT -> RELEASE -> IDLE. All of state, grant_port, ptr and pkt_count are registered.
- IDLE:
  - On a rising edge where req_port != 0, select the first i with req_port[i]=1, scanning ptr, ptr+1, ... modulo NUM_IN.
  - On that edge: grant_port = one-hot(i), owner=i, busy=1, pkt_count += 1 (wraps at 2^CNT_WIDTH), state -> GRANT.
  - Latency is one edge from a sampled req_port to the grant.
- GRANT:
  - grant_port and owner are held constant.
  - The block leaves GRANT on the first edge where all three hold: req_port[owner]=0, req_in[owner]=0 and ack_in=0 (handshake quiescent).
  - On that edge: grant_port=0, busy=0, ptr = (owner+1) mod NUM_IN, state -> RELEASE.
  - If req_port[owner] falls while a handshake is still in flight, the grant is held until the handshake completes.
- RELEASE:
  - One mandatory dead cycle with no grant. Guarantees no grant overlap across packets.
  - Always -> IDLE.
- Datapath (combinational from the registered owner and state):
  - When busy: data_out = data_in[owner], req_out = req_in[owner], ack_out[owner] = ack_in, all other ack_out bits = 0.
  - When not busy: data_out=0, req_out=0, ack_out=0.
  - req_in and data_in from non-owner inputs are ignored; no ack is ever returned to them.
- Four-phase protocol is passed through unaltered and the block adds no flit latency:
  - sender raises req with data stable;
  - receiver raises ack;
  - sender drops req;
  - receiver drops ack.
- Simultaneous requests: exactly one grant, by round-robin order from ptr. The owner always gets the next lowest priority after release.
- A new request arriving in GRANT or RELEASE is queued implicitly (its req_port is held) and is evaluated in IDLE.
- grant_port is never multi-hot. busy == |grant_port at all times.

Test Plan:
- Reset and single packet:
  - Stimulus: rst low for 5 ns, then high; raise req_port[0]; buffer_unit sends 3 flits 0x00001, 0x00002, 0x00003 with ack_in returned by a receiving node.
  - Required response: grant_port=5'b00001 one edge after req_port[0]; data_out reproduces the 3 flits in order; grant drops and RELEASE lasts one cycle after req_port[0] falls; pkt_count=1.
- Round-robin fairness:
  - Stimulus: req_port=5'b11111 held continuously, each owner sending one 1-flit packet.
  - Required response: grant order 0,1,2,3,4,0; a zero-grant cycle between each pair of grants; pkt_count=6.
- Pointer wrap:
  - Stimulus: ptr=4 (after granting input 3); req_port=5'b00011.
  - Required response: grant goes to input 0, then to input 1.
- Early req_port drop:
  - Stimulus: owner 2 drops req_port[2] while req_out=1 and ack_in=0.
  - Required response: grant_port stays 5'b00100 until ack_in rises and falls, then clears on the following edge.
- Isolation:
  - Stimulus: while input 1 owns the port, toggle req_in[3] and data_in slice 3.
  - Required response: ack_out[3]=0; req_out and data_out track input 1 only.
- Reset mid-packet:
  - Stimulus: assert rst low during flit 2 of a packet.
  - Required response: grant_port, req_out, ack_out and busy go to 0 immediately without waiting for clk; pkt_count=0; after release, the first grant follows priority from ptr=0.

Source files
------------

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin, packet-granular allocator for one mesh router output
// Holds a grant for a whole packet and passes the owner's four-phase handshake straight through.
module output_port_arbiter #(
   parameter int NUM_IN     = 5,
   parameter int DATA_WIDTH = 18,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_IN-1:0]              req_port,
   output logic [NUM_IN-1:0]              grant_port,
   input  logic [NUM_IN*DATA_WIDTH-1:0]   data_in,
   input  logic [NUM_IN-1:0]              req_in,
   output logic [NUM_IN-1:0]              ack_out,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           req_out,
   input  logic                           ack_in,
   output logic                           busy,
   output logic [CNT_WIDTH-1:0]           pkt_count
);

   localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT   = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   logic [1:0]       state;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] sel_idx;
   logic [PTR_W-1:0] scan_idx;
   logic [PTR_W-1:0] next_ptr;
   logic             sel_found;
   logic             release_ok;
   int               idx;

   // Scan from the far end back towards ptr so the candidate closest to ptr wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_idx  = '0;
      idx       = 0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_IN) begin
            idx = idx - NUM_IN;
         end
         scan_idx = PTR_W'(idx);
         if (req_port[scan_idx]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx;
         end
      end
   end

   assign next_ptr   = (owner == PTR_W'(NUM_IN - 1)) ? '0 : owner + 1'b1;
   // Only release once the owner's packet request and its handshake are both idle.
   assign release_ok = !req_port[owner] && !req_in[owner] && !ack_in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         grant_port <= '0;
         owner      <= '0;
         ptr        <= '0;
         pkt_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  grant_port <= {{(NUM_IN-1){1'b0}}, 1'b1} << sel_idx;
                  owner      <= sel_idx;
                  pkt_count  <= pkt_count + 1'b1;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               if (release_ok) begin
                  grant_port <= '0;
                  ptr        <= next_ptr;
                  state      <= RELEASE;
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: begin
               grant_port <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign busy = |grant_port;

   always_comb begin
      data_out = '0;
      req_out  = 1'b0;
      ack_out  = '0;
      if (busy) begin
         data_out       = data_in[owner*DATA_WIDTH +: DATA_WIDTH];
         req_out        = req_in[owner];
         ack_out[owner] = ack_in;
      end
   end

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - scoreboard bench for output_port_arbiter
module tb_output_port_arbiter;

   localparam int NUM_IN = 5;
   localparam int DW     = 18;
   localparam int CW     = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_IN-1:0]    req_port;
   logic [NUM_IN-1:0]    grant_port;
   logic [NUM_IN*DW-1:0] data_in;
   logic [NUM_IN-1:0]    req_in;
   logic [NUM_IN-1:0]    ack_out;
   logic [DW-1:0]        data_out;
   logic                 req_out;
   logic                 ack_in;
   logic                 busy;
   logic [CW-1:0]        pkt_count;

   int            checks = 0;
   int            errors = 0;
   int            exp_grant[$];
   logic [DW-1:0] exp_flit[$];
   int            exp_rr[6] = '{0, 1, 2, 3, 4, 0};

   output_port_arbiter #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .req_port(req_port), .grant_port(grant_port),
      .data_in(data_in), .req_in(req_in), .ack_out(ack_out), .data_out(data_out),
      .req_out(req_out), .ack_in(ack_in), .busy(busy), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] d);
      data_in[i*DW +: DW] = d;
   endtask

   task automatic send_flit(input int i, input logic [DW-1:0] d);
      exp_flit.push_back(d);
      set_data(i, d);
      req_in[i] = 1'b1;
      step();
      ack_in = 1'b1;
      step();
      check("flit_ack_out", 32'(ack_out), 32'(1) << i);
      req_in[i] = 1'b0;
      step();
      ack_in = 1'b0;
      step();
   endtask

   task automatic wait_grant(input string name, output int who);
      who = -1;
      for (int t = 0; t < 8; t++) begin
         if (grant_port != '0) break;
         step();
      end
      checks++;
      if (grant_port == '0) begin
         errors++;
         $display("FAIL %s_timeout: actual=0x0 required=nonzero grant", name);
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (grant_port[i]) who = i;
         end
      end
   endtask

   // Monitor: pops expected grants and flits whenever the DUT presents a new one.
   initial begin
      logic [NUM_IN-1:0] pg;
      logic              pr;
      int                e;
      logic [DW-1:0]     ef;
      pg = '0;
      pr = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pg = '0;
            pr = 1'b0;
         end else begin
            check("busy_vs_grant", 32'(busy), 32'(|grant_port));
            check("grant_onehot0", 32'($onehot0(grant_port)), 32'd1);
            if (grant_port != '0 && pg == '0) begin
               if (exp_grant.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_grant: actual=0x%0h required=none", grant_port);
               end else begin
                  e = exp_grant.pop_front();
                  check("grant_order", 32'(grant_port), 32'(1) << e);
               end
            end
            if (req_out && !pr) begin
               if (exp_flit.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_flit: actual=0x%0h required=none", data_out);
               end else begin
                  ef = exp_flit.pop_front();
                  check("flit_data", 32'(data_out), 32'(ef));
               end
            end
            pg = grant_port;
            pr = req_out;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int who;
      logic [DW-1:0] d;
      req_port = '0;
      req_in   = '0;
      ack_in   = 1'b0;
      data_in  = '0;
      rst      = 1'b0;

      // reset state
      #3;
      check("rst_grant", 32'(grant_port), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      check("rst_req_out", 32'(req_out), 32'd0);
      check("rst_ack_out", 32'(ack_out), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      #2 rst = 1'b1;
      step();

      // single packet from input 0
      exp_grant.push_back(0);
      req_port = 5'b00001;
      step();
      check("t1_grant", 32'(grant_port), 32'h01);
      send_flit(0, 18'h00001);
      send_flit(0, 18'h00002);
      send_flit(0, 18'h00003);
      req_port[0] = 1'b0;
      step();
      check("t1_release", 32'(grant_port), 32'd0);
      check("t1_release_busy", 32'(busy), 32'd0);
      step();
      check("t1_idle", 32'(grant_port), 32'd0);
      check("t1_pkt_count", 32'(pkt_count), 32'd1);

      // round-robin fairness from a fresh pointer
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("t2_pkt_count_reset", 32'(pkt_count), 32'd0);
      for (int n = 0; n < 6; n++) exp_grant.push_back(exp_rr[n]);
      req_port = 5'b11111;
      for (int n = 0; n < 6; n++) begin
         wait_grant("t2", who);
         if (who < 0) break;
         check("t2_owner", 32'(who), 32'(exp_rr[n]));
         d = DW'(32'h100 + n);
         send_flit(who, d);
         if (n == 5) req_port = '0;
         else req_port[who] = 1'b0;
         step();
         check("t2_gap", 32'(grant_port), 32'd0);
         if (n < 5) req_port[who] = 1'b1;
      end
      step();
      step();
      check("t2_pkt_count", 32'(pkt_count), 32'd6);

      // pointer wrap: grant 3 leaves ptr=4
      exp_grant.push_back(3);
      req_port = 5'b01000;
      wait_grant("t3a", who);
      check("t3_owner3", 32'(who), 32'd3);
      send_flit(3, 18'h03003);
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      req_port = 5'b00011;
      step();
      check("t3_release", 32'(grant_port), 32'd0);
      wait_grant("t3b", who);
      check("t3_owner0", 32'(who), 32'd0);
      send_flit(0, 18'h000a0);
      req_port[0] = 1'b0;
      step();
      wait_grant("t3c", who);
      check("t3_owner1", 32'(who), 32'd1);
      send_flit(1, 18'h000b1);
      req_port = '0;
      step();
      check("t3_done", 32'(grant_port), 32'd0);

      // early req_port drop with handshake in flight
      exp_grant.push_back(2);
      req_port = 5'b00100;
      wait_grant("t4", who);
      check("t4_owner", 32'(who), 32'd2);
      exp_flit.push_back(18'h02222);
      set_data(2, 18'h02222);
      req_in[2] = 1'b1;
      step();
      check("t4_req_out", 32'(req_out), 32'd1);
      req_port[2] = 1'b0;
      step();
      check("t4_hold_req", 32'(grant_port), 32'h04);
      ack_in = 1'b1;
      step();
      check("t4_hold_ack", 32'(grant_port), 32'h04);
      req_in[2] = 1'b0;
      step();
      check("t4_hold_ackonly", 32'(grant_port), 32'h04);
      ack_in = 1'b0;
      step();
      check("t4_clear", 32'(grant_port), 32'd0);

      // isolation of a non-owner input
      exp_grant.push_back(1);
      req_port = 5'b00010;
      wait_grant("t5", who);
      check("t5_owner", 32'(who), 32'd1);
      exp_flit.push_back(18'h00155);
      set_data(1, 18'h00155);
      set_data(3, 18'h3aaaa);
      req_in[1] = 1'b1;
      req_in[3] = 1'b1;
      step();
      check("t5_data", 32'(data_out), 32'h155);
      ack_in = 1'b1;
      step();
      check("t5_ack_out", 32'(ack_out), 32'h02);
      req_in[3] = 1'b0;
      set_data(3, 18'h12345);
      step();
      check("t5_req_track", 32'(req_out), 32'd1);
      check("t5_data_track", 32'(data_out), 32'h155);
      req_in[1] = 1'b0;
      req_in[3] = 1'b1;
      step();
      check("t5_req_drop", 32'(req_out), 32'd0);
      check("t5_ack_iso", 32'(ack_out), 32'h02);
      ack_in = 1'b0;
      req_in[3] = 1'b0;
      req_port = '0;
      step();
      check("t5_release", 32'(grant_port), 32'd0);

      // asynchronous reset in the middle of flit 2
      exp_grant.push_back(0);
      req_port = 5'b00001;
      wait_grant("t6", who);
      check("t6_owner", 32'(who), 32'd0);
      send_flit(0, 18'h00001);
      exp_flit.push_back(18'h00002);
      set_data(0, 18'h00002);
      req_in[0] = 1'b1;
      step();
      ack_in = 1'b1;
      step();
      #2 rst = 1'b0;
      #1;
      check("t6_rst_grant", 32'(grant_port), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_req_out", 32'(req_out), 32'd0);
      check("t6_rst_ack_out", 32'(ack_out), 32'd0);
      check("t6_rst_data_out", 32'(data_out), 32'd0);
      check("t6_rst_pkt_count", 32'(pkt_count), 32'd0);
      req_in   = '0;
      ack_in   = 1'b0;
      req_port = 5'b01010;
      exp_grant.push_back(1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      wait_grant("t6_after", who);
      check("t6_ptr0_owner", 32'(who), 32'd1);
      check("t6_pkt_count", 32'(pkt_count), 32'd1);
      req_port = '0;
      step();
      check("t6_release", 32'(grant_port), 32'd0);
      step();

      check("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
      check("flit_queue_empty", 32'(exp_flit.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
